frame_disassembler: RTL

- Receive-side counterpart of the TX frame assembler.
- Takes the demodulated sample stream of one burst frame: a 480-sample sync/channel-estimation preamble, then 8 OFDM symbols of 16 CP + 64 data samples (1120 samples total).
- Discards the preamble and every cyclic prefix, stores each 64-sample symbol in a ping-pong symbol buffer, and drains symbols to the FFT stage over a valid/ready interface.

---
 rtl/frame_disassembler.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_disassembler.sv
// Receive frame disassembler: drops preamble and cyclic prefixes, buffers each symbol
// in a ping-pong RAM, streams symbols out valid/ready. `FRAME_CNT_EN adds frame/drop counters.
module frame_disassembler #(
  parameter int SYMBOL_NUM   = 8,
  parameter int FFT_POINT    = 64,
  parameter int CP_NUM       = 16,
  parameter int PREAMBLE_NUM = 480,
  parameter int DATA_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  input  logic                          frame_start,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_first,
  output logic                          dout_last,
  output logic [$clog2(SYMBOL_NUM)-1:0] sym_idx,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          busy
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int PW = $clog2(PREAMBLE_NUM);
  localparam int CW = $clog2(CP_NUM);
  localparam int AW = $clog2(FFT_POINT);
  localparam int SW = $clog2(SYMBOL_NUM);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_NUM - 1);
  localparam logic [CW-1:0] CP_LAST  = CW'(CP_NUM - 1);
  localparam logic [AW-1:0] PAY_LAST = AW'(FFT_POINT - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOL_NUM - 1);

  typedef enum logic [1:0] {IDLE, SKIP_PRE, SKIP_CP, PAYLOAD} wr_state_e;

  wr_state_e         state_q, state_d;
  logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]     cp_cnt_q, cp_cnt_d;
  logic [AW-1:0]     pay_cnt_q, pay_cnt_d;
  logic [SW-1:0]     sym_cnt_q, sym_cnt_d;
  logic              drop_q, drop_d;

  logic              start, abort;
  logic              wr_en, sym_end, frame_end, bank_set, drop_evt;

  logic [1:0]        bank_full_q, bank_set_vec, bank_clr;
  logic [1:0][SW-1:0] tag_q;
  logic              wr_bank_q, rd_bank_q, iss_bank_q;
  logic [AW-1:0]     iss_addr_q;
  logic              issue, out_adv, p1_free, xfer, drain_end;

  logic [DATA_W-1:0] mem [0:2*FFT_POINT-1];
  logic [DATA_W-1:0] data_p1_q, dout_p2_q;
  logic              vld_p1_q, first_p1_q, last_p1_q;
  logic [SW-1:0]     idx_p1_q, idx_p2_q;
  logic              vld_p2_q, first_p2_q, last_p2_q;

  logic              overflow_q, busy_q, fin_q, frame_done_q;

  assign start = din_valid & frame_start;
  // Any frame_start while a frame is still being written or drained restarts everything.
  assign abort = start & busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      cp_cnt_q  <= '0;
      pay_cnt_q <= '0;
      sym_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      cp_cnt_q  <= cp_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    cp_cnt_d  = cp_cnt_q;
    pay_cnt_d = pay_cnt_q;
    sym_cnt_d = sym_cnt_q;
    drop_d    = drop_q;
    if (start) begin
      state_d   = SKIP_PRE;
      pre_cnt_d = PW'(1);
      cp_cnt_d  = '0;
      pay_cnt_d = '0;
      sym_cnt_d = '0;
      drop_d    = 1'b0;
    end else if (din_valid) begin
      case (state_q)
        SKIP_PRE: begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d  = SKIP_CP;
            cp_cnt_d = '0;
          end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
          end
        end
        SKIP_CP: begin
          if (cp_cnt_q == CP_LAST) begin
            state_d   = PAYLOAD;
            pay_cnt_d = '0;
            // A bank freed by the drain in this same cycle counts as free.
            drop_d    = bank_full_q[wr_bank_q] & ~bank_clr[wr_bank_q];
          end else begin
            cp_cnt_d = cp_cnt_q + CW'(1);
          end
        end
        PAYLOAD: begin
          pay_cnt_d = pay_cnt_q + AW'(1);
          if (pay_cnt_q == PAY_LAST) begin
            if (sym_cnt_q == SYM_LAST) begin
              state_d = IDLE;
            end else begin
              state_d   = SKIP_CP;
              cp_cnt_d  = '0;
              sym_cnt_d = sym_cnt_q + SW'(1);
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    sym_end = 1'b0;
    if (din_valid && !start && state_q == PAYLOAD) begin
      wr_en   = ~drop_q;
      sym_end = (pay_cnt_q == PAY_LAST);
    end
  end

  assign frame_end    = sym_end & (sym_cnt_q == SYM_LAST);
  assign bank_set     = sym_end & ~drop_q;
  assign drop_evt     = sym_end & drop_q;
  assign bank_set_vec = {bank_set & wr_bank_q, bank_set & ~wr_bank_q};

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, pay_cnt_q}] <= din;
  end

  assign out_adv   = ~vld_p2_q | dout_ready;
  assign p1_free   = ~vld_p1_q | out_adv;
  assign issue     = bank_full_q[iss_bank_q] & p1_free;
  assign xfer      = vld_p2_q & dout_ready;
  assign drain_end = xfer & last_p2_q;
  assign bank_clr  = {drain_end & rd_bank_q, drain_end & ~rd_bank_q};

  // Issue pointer runs ahead of rd_bank so the next symbol follows without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= '0;
      tag_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      iss_bank_q  <= 1'b0;
      iss_addr_q  <= '0;
    end else if (abort) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      iss_bank_q  <= 1'b0;
      iss_addr_q  <= '0;
    end else begin
      bank_full_q <= (bank_full_q & ~bank_clr) | bank_set_vec;
      if (bank_set) begin
        tag_q[wr_bank_q] <= sym_cnt_q;
        wr_bank_q        <= ~wr_bank_q;
      end
      if (drain_end) rd_bank_q <= ~rd_bank_q;
      if (issue) begin
        iss_addr_q <= iss_addr_q + AW'(1);
        if (iss_addr_q == PAY_LAST) iss_bank_q <= ~iss_bank_q;
      end
    end
  end

  // Stage p1: synchronous RAM read (prefetch register)
  always_ff @(posedge clk) begin
    if (issue) data_p1_q <= mem[{iss_bank_q, iss_addr_q}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      idx_p1_q   <= '0;
    end else if (abort) begin
      vld_p1_q <= 1'b0;
    end else if (issue) begin
      vld_p1_q   <= 1'b1;
      first_p1_q <= (iss_addr_q == '0);
      last_p1_q  <= (iss_addr_q == PAY_LAST);
      idx_p1_q   <= tag_q[iss_bank_q];
    end else if (out_adv) begin
      vld_p1_q <= 1'b0;
    end
  end

  // Stage p2: output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q   <= 1'b0;
      dout_p2_q  <= '0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
      idx_p2_q   <= '0;
    end else if (abort) begin
      vld_p2_q <= 1'b0;
    end else if (out_adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        dout_p2_q  <= data_p1_q;
        first_p2_q <= first_p1_q;
        last_p2_q  <= last_p1_q;
        idx_p2_q   <= idx_p1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (start) begin
      overflow_q   <= 1'b0;
      busy_q       <= 1'b1;
      fin_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (drop_evt) overflow_q <= 1'b1;
      frame_done_q <= fin_q & ~|bank_full_q;
      if (fin_q && bank_full_q == 2'b00) begin
        fin_q  <= 1'b0;
        busy_q <= 1'b0;
      end
      if (frame_end) fin_q <= 1'b1;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (!start && fin_q && bank_full_q == 2'b00) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_evt) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

  assign dout       = dout_p2_q;
  assign dout_valid = vld_p2_q;
  assign dout_first = first_p2_q;
  assign dout_last  = last_p2_q;
  assign sym_idx    = idx_p2_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule
